fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
// - Packet-aware round-robin arbiter sharing one sync_fifo write port among N_SRC AXI-Stream sources.
// - Registers a grant, holds it until tlast or the burst limit, then rotates priority.
// - Packs {src_id, tlast, tdata} into each FIFO word so the read side can demultiplex.
// - Sits between the per-probe capture streams and the shared sync_fifo.
// PARAMETERS
// - N_SRC      4    number of requesting sources (2..16)
// - DWIDTH     32   tdata width per source
// - MAX_BURST  0    max beats per grant before forced release; 0 = unlimited (release on tlast only)
// - IDW        derived: N_SRC>1 ? $clog2(N_SRC) : 1; not user-set
// PORTS
// - clk            in   1                clock
// - rst            in   1                synchronous, active-high reset
// - s_tdata        in   N_SRC*DWIDTH     source data, source i at [i*DWIDTH +: DWIDTH]
// - s_tvalid       in   N_SRC            per-source valid
// - s_tlast        in   N_SRC            per-source end of packet
// - s_tready       out  N_SRC            per-source ready; at most one bit high
// - fifo_wr_data   out  IDW+1+DWIDTH     {src_id, tlast, tdata} to sync_fifo wr_data
// - fifo_wr_en     out  1                write strobe to sync_fifo
// - fifo_wr_full   in   1                sync_fifo wr_full
// - grant_valid    out  1                a source currently holds the grant
// - grant_id       out  IDW              id of granted source; 0 when grant_valid=0
// BEHAVIOUR
// - Reset: state=IDLE, grant_valid=0, grant_id=0, s_tready=0, fifo_wr_en=0, beat_cnt=0, rr_last=N_SRC-1 (source 0 has first priority).
// - FSM IDLE: if any s_tvalid, pick the first asserted index from rr_last+1 upward, modulo N_SRC.
//   - Register it into grant_id and set rr_last to it; next state=BUSY. No beat is accepted in IDLE.
// - FSM BUSY:
//   - s_tready[grant_id] = ~fifo_wr_full; all other ready bits 0. Comb, so ready never asserts when full.
//   - Beat = s_tvalid[g] & s_tready[g]. fifo_wr_en = beat exactly.
//   - fifo_wr_data = {grant_id, s_tlast[g], s_tdata[g]}, driven combinationally.
//   - On a beat: beat_cnt++.
//   - Release when beat & (s_tlast[g] | (MAX_BURST!=0 & beat_cnt==MAX_BURST-1)).
//   - Release: next state=IDLE, beat_cnt=0, grant_valid=0.
//   - Valid dropping mid-packet: grant held, no timeout.
// - Latency: a request seen in cycle t gets its grant in t+1; first beat accepted no earlier than t+1.
//   - One IDLE bubble cycle between consecutive grants.
// - Simultaneous tlast and burst limit on the same beat: single release, counted once.
// - fifo_wr_full high in BUSY: ready=0, stalls with no data loss; grant retained.
// - Requester deasserts valid in IDLE before the grant registers: grant still issued.
//   - The pick used valid in IDLE, so BUSY waits for valid.
// - rr_last wraps N_SRC-1 -> 0. beat_cnt width: $clog2(MAX_BURST+1), min 1.
// - rst mid-packet: grant dropped immediately, in-flight packet truncated in the FIFO.
//   - The FIFO's own rst handles flushing.
// STRUCTURE
// - Package easyobv_arb_pkg: typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t.
//   - Package also holds function rr_pick(req, last) returning {found, idx}.
// - Sub-module rr_pick_comb: purely combinational rotate-and-priority-encode. Instantiated once.
// - Top holds FSM, rr_last, grant, beat_cnt, data/ready muxing.
// TESTING
// - Single source: src0 sends 3-beat packet 0xA0..0xA2 with tlast on the 3rd.
//   -> 3 writes: {0,0,A0},{0,0,A1},{0,1,A2}; then IDLE; grant_valid pulses over 3 cycles.
// - All 4 sources valid with 1-beat packets.
//   -> grant order 0,1,2,3,0, each separated by one IDLE cycle; fifo_wr_data ids match.
// - MAX_BURST=2, src1 sends 5-beat packet while src2 valid.
//   -> src1 2 beats, src2 packet, src1 resumes with the remaining 3 beats (in 2+1 bursts).
// - fifo_wr_full held high 4 cycles mid-packet.
//   -> s_tready=0 and fifo_wr_en=0 those cycles; grant_id unchanged; no beat lost or duplicated.
// - rst asserted in BUSY after beat 1 of a 4-beat packet.
//   -> next cycle s_tready=0, grant_valid=0, rr_last=N_SRC-1; src0 wins first after release.
// - Source valid deasserts 3 cycles mid-packet while another source requests.
//   -> grant held; other source served only after tlast.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the FIFO write-port arbiter.
package easyobv_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    localparam int RR_MAX_SRC = 16;
    localparam int RR_IDX_W   = 4;

    // Returns {found, idx}: first set bit of req scanning upward from last+1, wrapping at n.
    function automatic logic [RR_IDX_W:0] rr_pick(input logic [RR_MAX_SRC-1:0] req,
                                                   input logic [RR_IDX_W-1:0]   last,
                                                   input int                    n);
        logic                found;
        logic [RR_IDX_W-1:0] idx;
        int                  cand;
        found = 1'b0;
        idx   = '0;
        for (int off = 1; off <= RR_MAX_SRC; off++) begin
            cand = int'(last) + off;
            if (cand >= n) cand = cand - n;
            if (off <= n && !found && req[cand[RR_IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = cand[RR_IDX_W-1:0];
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_pick.sv
// Combinational rotate-and-priority-encode wrapper around rr_pick.
module rr_pick_comb
    import easyobv_arb_pkg::*;
#(
    parameter  int N_SRC = 4,
    localparam int IDW   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDW-1:0]   last,
    output logic             found,
    output logic [IDW-1:0]   idx
);

    logic [RR_IDX_W:0] pick;

    assign pick  = rr_pick(RR_MAX_SRC'(req), RR_IDX_W'(last), N_SRC);
    assign found = pick[RR_IDX_W];
    assign idx   = IDW'(pick[RR_IDX_W-1:0]);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter sharing one sync_fifo write port among N_SRC streams.
// Each FIFO word is {src_id, tlast, tdata} so the read side can demultiplex.
module fifo_wr_arbiter
    import easyobv_arb_pkg::*;
#(
    parameter  int N_SRC     = 4,
    parameter  int DWIDTH    = 32,
    parameter  int MAX_BURST = 0,
    localparam int IDW       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_SRC*DWIDTH-1:0] s_tdata,
    input  logic [N_SRC-1:0]        s_tvalid,
    input  logic [N_SRC-1:0]        s_tlast,
    output logic [N_SRC-1:0]        s_tready,
    output logic [IDW+DWIDTH:0]     fifo_wr_data,
    output logic                    fifo_wr_en,
    input  logic                    fifo_wr_full,
    output logic                    grant_valid,
    output logic [IDW-1:0]          grant_id
);

    localparam int             BCW           = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [BCW-1:0] LAST_BEAT_CNT = BCW'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);
    localparam logic [IDW-1:0] RR_RESET      = IDW'(N_SRC - 1);

    arb_state_t        state, state_next;
    logic [IDW-1:0]    grant_q;
    logic [IDW-1:0]    rr_last;
    logic [BCW-1:0]    beat_cnt;
    logic              pick_found;
    logic [IDW-1:0]    pick_idx;
    logic              sel_valid;
    logic              sel_last;
    logic [DWIDTH-1:0] sel_data;
    logic              burst_hit;
    logic              beat;
    logic              rel_now;

    rr_pick_comb #(.N_SRC(N_SRC)) u_pick (
        .req   (s_tvalid),
        .last  (rr_last),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign sel_valid = s_tvalid[grant_q];
    assign sel_last  = s_tlast[grant_q];
    assign sel_data  = s_tdata[int'(grant_q)*DWIDTH +: DWIDTH];
    assign burst_hit = (MAX_BURST != 0) && (beat_cnt == LAST_BEAT_CNT);

    // Ready is derived combinationally from full so no beat is ever offered into a full FIFO.
    always_comb begin
        state_next = state;
        s_tready   = '0;
        beat       = 1'b0;
        rel_now    = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_found) state_next = ARB_BUSY;
            end
            ARB_BUSY: begin
                s_tready[grant_q] = ~fifo_wr_full;
                beat              = sel_valid & ~fifo_wr_full;
                rel_now           = beat & (sel_last | burst_hit);
                if (rel_now) state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    assign fifo_wr_en   = beat;
    assign fifo_wr_data = {grant_q, sel_last, sel_data};
    assign grant_valid  = (state == ARB_BUSY);
    assign grant_id     = grant_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            grant_q  <= '0;
            rr_last  <= RR_RESET;
            beat_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ARB_IDLE && pick_found) begin
                grant_q <= pick_idx;
                rr_last <= pick_idx;
            end
            // tlast and burst limit on the same beat collapse into one release.
            if (rel_now) begin
                beat_cnt <= '0;
                grant_q  <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + BCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: one unlimited-burst instance and one MAX_BURST=2 instance.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IDW = 2;
    localparam int WW = IDW + 1 + DW;
    localparam int ND = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*DW-1:0] s_tdata      [ND];
    logic [N-1:0]    s_tvalid     [ND];
    logic [N-1:0]    s_tlast      [ND];
    logic [N-1:0]    s_tready     [ND];
    logic [WW-1:0]   fifo_wr_data [ND];
    logic            fifo_wr_en   [ND];
    logic            fifo_wr_full [ND];
    logic            grant_valid  [ND];
    logic [IDW-1:0]  grant_id     [ND];

    // Source models: npk packets of len beats, data = base + running beat count.
    int           len  [ND][N];
    int           npk  [ND][N];
    int           cnt  [ND][N];
    int           seq  [ND][N];
    logic [DW-1:0] base [ND][N];
    bit           hold [ND][N];
    logic [N-1:0] acc  [ND];

    logic [WW-1:0] exp_q[$];
    logic [WW-1:0] exp_qb[$];

    int n_cmp  = 0;
    int n_fail = 0;

    int rr_gv  [11] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    int rr_gid [11] = '{0, 0, 0, 1, 0, 2, 0, 3, 0, 0, 0};
    int bu_gv  [11] = '{0, 1, 1, 0, 1, 0, 1, 1, 0, 1, 0};
    int bu_gid [11] = '{0, 1, 1, 0, 2, 0, 1, 1, 0, 1, 0};
    int co_gv  [7]  = '{0, 1, 1, 0, 1, 1, 0};

    fifo_wr_arbiter #(.N_SRC(N), .DWIDTH(DW), .MAX_BURST(0)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .s_tdata      (s_tdata[0]),
        .s_tvalid     (s_tvalid[0]),
        .s_tlast      (s_tlast[0]),
        .s_tready     (s_tready[0]),
        .fifo_wr_data (fifo_wr_data[0]),
        .fifo_wr_en   (fifo_wr_en[0]),
        .fifo_wr_full (fifo_wr_full[0]),
        .grant_valid  (grant_valid[0]),
        .grant_id     (grant_id[0])
    );

    fifo_wr_arbiter #(.N_SRC(N), .DWIDTH(DW), .MAX_BURST(2)) u_dut_burst (
        .clk          (clk),
        .rst          (rst),
        .s_tdata      (s_tdata[1]),
        .s_tvalid     (s_tvalid[1]),
        .s_tlast      (s_tlast[1]),
        .s_tready     (s_tready[1]),
        .fifo_wr_data (fifo_wr_data[1]),
        .fifo_wr_en   (fifo_wr_en[1]),
        .fifo_wr_full (fifo_wr_full[1]),
        .grant_valid  (grant_valid[1]),
        .grant_id     (grant_id[1])
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard helpers
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] word(input int id, input bit last, input logic [DW-1:0] data);
        return {IDW'(id), last, data};
    endfunction

    task automatic push(input int d, input logic [WW-1:0] w);
        if (d == 0) exp_q.push_back(w);
        else        exp_qb.push_back(w);
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? exp_q.size() : exp_qb.size();
    endfunction

    function automatic logic [WW-1:0] pop(input int d);
        if (d == 0) return exp_q.pop_front();
        return exp_qb.pop_front();
    endfunction

    // Driver tasks
    task automatic drive_inputs();
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < N; i++) begin
                if (npk[d][i] > 0) begin
                    s_tvalid[d][i]         = !hold[d][i];
                    s_tlast[d][i]          = (cnt[d][i] == len[d][i] - 1);
                    s_tdata[d][i*DW +: DW] = base[d][i] + DW'(seq[d][i]);
                end else begin
                    s_tvalid[d][i]         = 1'b0;
                    s_tlast[d][i]          = 1'b0;
                    s_tdata[d][i*DW +: DW] = '0;
                end
            end
        end
    endtask

    task automatic load(input int d, input int i, input int n_pk, input int n_len, input logic [DW-1:0] b);
        npk[d][i]  = n_pk;
        len[d][i]  = n_len;
        cnt[d][i]  = 0;
        seq[d][i]  = 0;
        base[d][i] = b;
        hold[d][i] = 1'b0;
    endtask

    task automatic edge2();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input int d, input string tag);
        int k = 0;
        while (k < 60 && (qsize(d) != 0 || grant_valid[d] !== 1'b0)) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_queue_drained"}, 64'(qsize(d)), 64'd0);
        check({tag, "_idle_after"}, 64'(grant_valid[d]), 64'd0);
    endtask

    // Source players: advance on beats seen before the edge, then re-drive after it.
    initial forever begin
        @(negedge clk);
        for (int d = 0; d < ND; d++) acc[d] = rst ? '0 : (s_tvalid[d] & s_tready[d]);
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < N; i++) begin
                if (acc[d][i]) begin
                    seq[d][i]++;
                    cnt[d][i]++;
                    if (cnt[d][i] == len[d][i]) begin
                        cnt[d][i] = 0;
                        npk[d][i]--;
                    end
                end
            end
        end
        drive_inputs();
    end

    // FIFO write monitor
    initial forever begin
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            if (!rst && fifo_wr_en[d]) begin
                check($sformatf("wr_expected_%0d", d), 64'(qsize(d) != 0), 64'd1);
                if (qsize(d) != 0)
                    check($sformatf("wr_data_%0d", d), 64'(fifo_wr_data[d]), 64'(pop(d)));
            end
        end
    end

    // Directed sequence
    initial begin
        for (int d = 0; d < ND; d++) begin
            fifo_wr_full[d] = 1'b0;
            for (int i = 0; i < N; i++) load(d, i, 0, 1, '0);
        end
        drive_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("rst_grant_valid_%0d", d), 64'(grant_valid[d]), 64'd0);
            check($sformatf("rst_grant_id_%0d", d), 64'(grant_id[d]), 64'd0);
            check($sformatf("rst_tready_%0d", d), 64'(s_tready[d]), 64'd0);
            check($sformatf("rst_wr_en_%0d", d), 64'(fifo_wr_en[d]), 64'd0);
        end

        // Round robin over all four sources, src0 with a second packet
        edge2();
        rst = 1'b0;
        load(0, 0, 2, 1, 32'hB0);
        load(0, 1, 1, 1, 32'hC0);
        load(0, 2, 1, 1, 32'hD0);
        load(0, 3, 1, 1, 32'hE0);
        drive_inputs();
        push(0, word(0, 1, 32'hB0));
        push(0, word(1, 1, 32'hC0));
        push(0, word(2, 1, 32'hD0));
        push(0, word(3, 1, 32'hE0));
        push(0, word(0, 1, 32'hB1));
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            check($sformatf("rr_gv_c%0d", k), 64'(grant_valid[0]), 64'(rr_gv[k]));
            check($sformatf("rr_gid_c%0d", k), 64'(grant_id[0]), 64'(rr_gid[k]));
            check($sformatf("rr_wr_en_c%0d", k), 64'(fifo_wr_en[0]), 64'(rr_gv[k]));
        end
        drain(0, "rr");

        // Single source, 3-beat packet
        edge2();
        load(0, 0, 1, 3, 32'hA0);
        drive_inputs();
        push(0, word(0, 0, 32'hA0));
        push(0, word(0, 0, 32'hA1));
        push(0, word(0, 1, 32'hA2));
        @(negedge clk);
        check("single_idle_gv", 64'(grant_valid[0]), 64'd0);
        check("single_idle_wr_en", 64'(fifo_wr_en[0]), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("single_gv_b%0d", k), 64'(grant_valid[0]), 64'd1);
            check($sformatf("single_gid_b%0d", k), 64'(grant_id[0]), 64'd0);
            check($sformatf("single_ready_b%0d", k), 64'(s_tready[0]), 64'h1);
        end
        @(negedge clk);
        check("single_release_gv", 64'(grant_valid[0]), 64'd0);
        check("single_release_ready", 64'(s_tready[0]), 64'd0);
        drain(0, "single");

        // FIFO full for 4 cycles mid-packet
        edge2();
        load(0, 1, 1, 6, 32'h10);
        drive_inputs();
        for (int k = 0; k < 6; k++) push(0, word(1, k == 5, 32'h10 + DW'(k)));
        repeat (3) @(posedge clk);
        #2;
        fifo_wr_full[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("full_ready_c%0d", k), 64'(s_tready[0]), 64'd0);
            check($sformatf("full_wr_en_c%0d", k), 64'(fifo_wr_en[0]), 64'd0);
            check($sformatf("full_gv_c%0d", k), 64'(grant_valid[0]), 64'd1);
            check($sformatf("full_gid_c%0d", k), 64'(grant_id[0]), 64'd1);
        end
        check("full_beats_pending", 64'(exp_q.size()), 64'd4);
        edge2();
        fifo_wr_full[0] = 1'b0;
        drain(0, "full");

        // Valid drops mid-packet while another source waits
        edge2();
        load(0, 2, 1, 4, 32'h20);
        load(0, 3, 1, 1, 32'h30);
        drive_inputs();
        for (int k = 0; k < 4; k++) push(0, word(2, k == 3, 32'h20 + DW'(k)));
        push(0, word(3, 1, 32'h30));
        repeat (2) @(posedge clk);
        #2;
        hold[0][2] = 1'b1;
        drive_inputs();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("gap_gv_c%0d", k), 64'(grant_valid[0]), 64'd1);
            check($sformatf("gap_gid_c%0d", k), 64'(grant_id[0]), 64'd2);
            check($sformatf("gap_ready_c%0d", k), 64'(s_tready[0]), 64'h4);
            check($sformatf("gap_wr_en_c%0d", k), 64'(fifo_wr_en[0]), 64'd0);
        end
        edge2();
        hold[0][2] = 1'b0;
        drive_inputs();
        drain(0, "gap");

        // Reset after beat 1 of a 4-beat packet
        edge2();
        load(0, 1, 1, 4, 32'h40);
        drive_inputs();
        push(0, word(1, 0, 32'h40));
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        edge2();
        rst = 1'b0;
        check("rst_mid_queue", 64'(exp_q.size()), 64'd0);
        load(0, 0, 1, 1, 32'h50);
        load(0, 1, 1, 1, 32'h60);
        load(0, 2, 1, 1, 32'h70);
        drive_inputs();
        push(0, word(0, 1, 32'h50));
        push(0, word(1, 1, 32'h60));
        push(0, word(2, 1, 32'h70));
        @(negedge clk);
        check("rst_mid_gv", 64'(grant_valid[0]), 64'd0);
        check("rst_mid_ready", 64'(s_tready[0]), 64'd0);
        check("rst_mid_gid", 64'(grant_id[0]), 64'd0);
        check("rst_mid_wr_en", 64'(fifo_wr_en[0]), 64'd0);
        @(negedge clk);
        check("rst_first_gv", 64'(grant_valid[0]), 64'd1);
        check("rst_first_gid", 64'(grant_id[0]), 64'd0);
        drain(0, "rst_mid");

        // Burst limit 2: src1 5 beats shares with src2
        edge2();
        load(1, 1, 1, 5, 32'h80);
        load(1, 2, 1, 1, 32'h90);
        drive_inputs();
        push(1, word(1, 0, 32'h80));
        push(1, word(1, 0, 32'h81));
        push(1, word(2, 1, 32'h90));
        push(1, word(1, 0, 32'h82));
        push(1, word(1, 0, 32'h83));
        push(1, word(1, 1, 32'h84));
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            check($sformatf("burst_gv_c%0d", k), 64'(grant_valid[1]), 64'(bu_gv[k]));
            check($sformatf("burst_gid_c%0d", k), 64'(grant_id[1]), 64'(bu_gid[k]));
        end
        drain(1, "burst");

        // tlast coinciding with the burst limit releases once
        edge2();
        load(1, 1, 2, 2, 32'hC0);
        drive_inputs();
        push(1, word(1, 0, 32'hC0));
        push(1, word(1, 1, 32'hC1));
        push(1, word(1, 0, 32'hC2));
        push(1, word(1, 1, 32'hC3));
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check($sformatf("coin_gv_c%0d", k), 64'(grant_valid[1]), 64'(co_gv[k]));
        end
        drain(1, "coin");

        check("final_queue_a", 64'(exp_q.size()), 64'd0);
        check("final_queue_b", 64'(exp_qb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
